// File: rtl/keypad_scan_rx_pkg.sv
// Shared types and constants for the keypad scanner: FSM states, column patterns,
// key-code helpers and the key-code to calculator-symbol mapping.
package keypad_scan_rx_pkg;

  typedef logic [3:0] nibble_t;

  typedef enum logic [1:0] {
    ST_SCAN     = 2'd0,
    ST_DEBOUNCE = 2'd1,
    ST_HELD     = 2'd2,
    ST_RELEASE  = 2'd3
  } kp_state_e;

  localparam nibble_t COL_RESET = 4'b1110;
  localparam nibble_t ROWS_IDLE = 4'hF;

  typedef enum logic [3:0] {
    SYM_D0  = 4'd0,  SYM_D1  = 4'd1,  SYM_D2  = 4'd2,  SYM_D3  = 4'd3,
    SYM_D4  = 4'd4,  SYM_D5  = 4'd5,  SYM_D6  = 4'd6,  SYM_D7  = 4'd7,
    SYM_D8  = 4'd8,  SYM_D9  = 4'd9,  SYM_ADD = 4'd10, SYM_SUB = 4'd11,
    SYM_MUL = 4'd12, SYM_DIV = 4'd13, SYM_EQ  = 4'd14, SYM_CLR = 4'd15
  } calc_sym_e;

  function automatic nibble_t key_code_of(input logic [1:0] row, input logic [1:0] col);
    return {row, col};
  endfunction

  // Row 0 wins when several rows of the active column are low.
  function automatic logic [1:0] lowest_low_row(input nibble_t rows);
    logic [1:0] r;
    if (!rows[0]) begin
      r = 2'd0;
    end else if (!rows[1]) begin
      r = 2'd1;
    end else if (!rows[2]) begin
      r = 2'd2;
    end else begin
      r = 2'd3;
    end
    return r;
  endfunction

  function automatic nibble_t col_drive(input logic [1:0] idx);
    return ~(4'b0001 << idx);
  endfunction

  function automatic calc_sym_e key_symbol(input nibble_t code);
    calc_sym_e s;
    case (code)
      4'd0:    s = SYM_D1;
      4'd1:    s = SYM_D2;
      4'd2:    s = SYM_D3;
      4'd3:    s = SYM_ADD;
      4'd4:    s = SYM_D4;
      4'd5:    s = SYM_D5;
      4'd6:    s = SYM_D6;
      4'd7:    s = SYM_SUB;
      4'd8:    s = SYM_D7;
      4'd9:    s = SYM_D8;
      4'd10:   s = SYM_D9;
      4'd11:   s = SYM_MUL;
      4'd12:   s = SYM_CLR;
      4'd13:   s = SYM_D0;
      4'd14:   s = SYM_EQ;
      default: s = SYM_DIV;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/keypad_scan_rx_if.sv
// Keypad pin and key-report bundle; master is the scanner, slave is the board/consumer side.
interface keypad_scan_rx_if;
  import keypad_scan_rx_pkg::*;

  nibble_t row_in;
  nibble_t col_out;
  nibble_t key_code;
  logic    key_valid;
  logic    key_held;

  modport master (input row_in, output col_out, output key_code, output key_valid, output key_held);
  modport slave  (output row_in, input col_out, input key_code, input key_valid, input key_held);
endinterface

// File: rtl/keypad_scan_rx_scan_tick_gen.sv
// Reusable wrap-at-N divider: one-clk tick when the free-running count reaches SCAN_DIV-1.
module scan_tick_gen #(
  parameter int SCAN_DIV = 31250
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick
);

  localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(SCAN_DIV - 1);

  logic [CW-1:0] cnt_r;

  // Free-running divider count
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r <= '0;
    end else if (cnt_r == CNT_LAST) begin
      cnt_r <= '0;
    end else begin
      cnt_r <= cnt_r + CW'(1);
    end
  end

  assign tick = (cnt_r == CNT_LAST);

endmodule

// File: rtl/keypad_scan_rx.sv
// 4x4 matrix keypad scanner: rotates a single low column, synchronises and debounces the
// rows, and reports each accepted key once with a registered code, pulse and held flag.
module keypad_scan_rx
  import keypad_scan_rx_pkg::*;
#(
  parameter int SCAN_DIV       = 31250,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  keypad_scan_rx_if.master  kp
);

  localparam int DBW = $clog2(DEBOUNCE_SCANS) + 1;
  localparam logic [DBW-1:0] DB_ONE  = DBW'(1);
  localparam logic [DBW-1:0] DB_DONE = DBW'(DEBOUNCE_SCANS);

  logic            tick_s;
  nibble_t         row_meta_r;
  nibble_t         row_s;
  kp_state_e       state_r;
  logic [1:0]      col_idx_r;
  logic [1:0]      row_idx_r;
  logic [DBW-1:0]  db_r;
  nibble_t         col_out_r;
  nibble_t         key_code_r;
  logic            key_valid_r;
  logic            key_held_r;

  logic            row_lat_low_s;
  logic [1:0]      col_nxt_s;
  logic [DBW-1:0]  db_inc_s;

  scan_tick_gen #(.SCAN_DIV(SCAN_DIV)) u_tick (
    .clk   (clk),
    .rst_n (rst_n),
    .tick  (tick_s)
  );

  // Two-flop synchroniser for the asynchronous, pulled-up rows
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_meta_r <= ROWS_IDLE;
      row_s      <= ROWS_IDLE;
    end else begin
      row_meta_r <= kp.row_in;
      row_s      <= row_meta_r;
    end
  end

  assign row_lat_low_s = ~row_s[row_idx_r];
  assign col_nxt_s     = col_idx_r + 2'd1;
  assign db_inc_s      = db_r + DB_ONE;

  // Scan / debounce / hold / release FSM with column rotator and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= ST_SCAN;
      col_idx_r   <= 2'd0;
      row_idx_r   <= 2'd0;
      db_r        <= '0;
      col_out_r   <= COL_RESET;
      key_code_r  <= 4'd0;
      key_valid_r <= 1'b0;
      key_held_r  <= 1'b0;
    end else begin
      key_valid_r <= 1'b0;
      if (tick_s) begin
        case (state_r)
          ST_SCAN: begin
            if (row_s != ROWS_IDLE) begin
              // Column stays frozen; only the latched row is tracked from here on.
              row_idx_r <= lowest_low_row(row_s);
              db_r      <= DB_ONE;
              state_r   <= ST_DEBOUNCE;
            end else begin
              col_idx_r <= col_nxt_s;
              col_out_r <= col_drive(col_nxt_s);
            end
          end
          ST_DEBOUNCE: begin
            if (row_lat_low_s) begin
              db_r <= db_inc_s;
              if (db_inc_s == DB_DONE) begin
                key_code_r  <= key_code_of(row_idx_r, col_idx_r);
                key_valid_r <= 1'b1;
                key_held_r  <= 1'b1;
                state_r     <= ST_HELD;
              end else begin
                state_r <= ST_DEBOUNCE;
              end
            end else begin
              state_r   <= ST_SCAN;
              col_idx_r <= col_nxt_s;
              col_out_r <= col_drive(col_nxt_s);
            end
          end
          ST_HELD: begin
            if (!row_lat_low_s) begin
              db_r    <= DB_ONE;
              state_r <= ST_RELEASE;
            end else begin
              state_r <= ST_HELD;
            end
          end
          ST_RELEASE: begin
            if (!row_lat_low_s) begin
              db_r <= db_inc_s;
              if (db_inc_s == DB_DONE) begin
                key_held_r <= 1'b0;
                state_r    <= ST_SCAN;
                col_idx_r  <= col_nxt_s;
                col_out_r  <= col_drive(col_nxt_s);
              end else begin
                state_r <= ST_RELEASE;
              end
            end else begin
              state_r <= ST_HELD;
            end
          end
          default: begin
            state_r <= ST_SCAN;
          end
        endcase
      end
    end
  end

  assign kp.col_out   = col_out_r;
  assign kp.key_code  = key_code_r;
  assign kp.key_valid = key_valid_r;
  assign kp.key_held  = key_held_r;

endmodule

// File: tb/tb_keypad_scan_rx.sv
// Scoreboard bench for keypad_scan_rx: a keypad matrix model, tick-level timing model of
// when presses are accepted/released, and a decoupled monitor checking every key_valid.
module tb_keypad_scan_rx;

  localparam int SD = 8;
  localparam int DB = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] pressed = 16'h0000;
  logic [3:0]  row_drv;
  int          cyc;
  int          checks = 0;
  int          failures = 0;
  int          exp_q[$];
  logic [3:0]  model_code = 4'd0;
  int          last_e = 0;
  int          last_idx = 0;

  keypad_scan_rx_if kif();

  keypad_scan_rx #(.SCAN_DIV(SD), .DEBOUNCE_SCANS(DB)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .kp    (kif)
  );

  always #5 clk = ~clk;

  // A pressed key pulls its row low while its column is driven low.
  always_comb begin
    row_drv = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (pressed[r*4+c] && !kif.col_out[c]) row_drv[r] = 1'b0;
  end
  assign kif.row_in = row_drv;

  always @(posedge clk or negedge rst_n)
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cyc %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every key_valid pulse must match the head of the expected queue.
  initial begin
    logic prev_valid;
    int   e;
    prev_valid = 1'b0;
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1 && kif.key_valid === 1'b1) begin
        checks++;
        if (prev_valid) begin
          failures++;
          $display("FAIL valid_twice: got key_valid high on consecutive cycles expected one-clk pulse");
        end else if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL unexpected_key_valid: got code %0d expected no pulse (cyc %0d)", kif.key_code, cyc);
        end else begin
          e = exp_q.pop_front();
          if (kif.key_code !== 4'(e)) begin
            failures++;
            $display("FAIL key_code: got %0d expected %0d", kif.key_code, e);
          end
        end
      end
      prev_valid = (rst_n === 1'b1) && (kif.key_valid === 1'b1);
    end
  end

  task automatic wait_cyc(input int target);
    int guard = 0;
    while (cyc < target && guard < 5000) begin
      @(posedge clk);
      #1;
      guard++;
    end
    if (cyc != target) begin
      failures++;
      $display("FAIL wait_cyc: got cyc %0d expected %0d", cyc, target);
    end
  endtask

  function automatic logic [3:0] col_pat(input int c);
    logic [3:0] p;
    p = 4'hF;
    p[c % 4] = 1'b0;
    return p;
  endfunction

  // Tick edge (cycles since reset, multiple of SD) at which column c is next sampled.
  function automatic int samp(input int c);
    return last_e + SD * (1 + ((c - last_idx + 4) % 4));
  endfunction

  task automatic idle(input int k);
    last_e   = last_e + SD * k;
    last_idx = (last_idx + k) % 4;
  endtask

  // Press rows of column c just after the column becomes driven; hold for h ticks.
  task automatic press(input int c, input logic [3:0] rows, input int h);
    int s, rel, fall, back, lr;
    lr = 0;
    for (int r = 3; r >= 0; r--) if (rows[r]) lr = r;
    s = samp(c);
    wait_cyc(s - SD + 1);
    for (int r = 0; r < 4; r++) if (rows[r]) pressed[r*4+c] = 1'b1;
    rel = s - SD + 1 + SD * h;
    if (h >= DB) begin
      exp_q.push_back(lr*4 + c);
      model_code = 4'(lr*4 + c);
      wait_cyc(s + SD*(DB-1) - 1);
      chk("valid_early", kif.key_valid, 1'b0);
      chk("held_early", kif.key_held, 1'b0);
      wait_cyc(s + SD*(DB-1));
      chk("valid_at_accept", kif.key_valid, 1'b1);
      chk("held_at_accept", kif.key_held, 1'b1);
      chk("col_frozen", kif.col_out, col_pat(c));
      wait_cyc(rel);
      for (int r = 0; r < 4; r++) pressed[r*4+c] = 1'b0;
      fall = rel + SD*DB - 1;
      wait_cyc(fall - 1);
      chk("held_before_release", kif.key_held, 1'b1);
      wait_cyc(fall);
      chk("held_released", kif.key_held, 1'b0);
      chk("col_resume", kif.col_out, col_pat(c + 1));
      last_e = fall;
    end else begin
      wait_cyc(rel);
      for (int r = 0; r < 4; r++) pressed[r*4+c] = 1'b0;
      back = s + SD*h;
      wait_cyc(back - 1);
      chk("bounce_col_frozen", kif.col_out, col_pat(c));
      wait_cyc(back);
      chk("bounce_col_next", kif.col_out, col_pat(c + 1));
      chk("bounce_code_kept", kif.key_code, model_code);
      chk("bounce_not_held", kif.key_held, 1'b0);
      last_e = back;
    end
    last_idx = (c + 1) % 4;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int s;
    int n_idle[9] = '{1, 7, 8, 15, 16, 24, 31, 32, 33};
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_col", kif.col_out, 4'b1110);
    chk("rst_code", kif.key_code, 4'd0);
    chk("rst_valid", kif.key_valid, 1'b0);
    chk("rst_held", kif.key_held, 1'b0);
    @(negedge clk) rst_n = 1'b1;

    // Idle: column rotates on every 8th clock and wraps.
    foreach (n_idle[i]) begin
      wait_cyc(n_idle[i]);
      chk("idle_col", kif.col_out, col_pat((n_idle[i] / SD) % 4));
    end
    last_e = 32; last_idx = 0;

    // Reset in the middle of debouncing row3/col2.
    s = samp(2);
    wait_cyc(s - SD + 1);
    pressed[14] = 1'b1;
    wait_cyc(s + SD + 2);
    #3 rst_n = 1'b0;
    #1;
    chk("mid_rst_col", kif.col_out, 4'b1110);
    chk("mid_rst_held", kif.key_held, 1'b0);
    chk("mid_rst_valid", kif.key_valid, 1'b0);
    repeat (3) @(posedge clk);
    pressed = 16'h0000;
    @(negedge clk) rst_n = 1'b1;
    last_e = 0; last_idx = 0;
    idle(5);

    press(1, 4'b0100, 5);            // key 9, scanning resumes at column 2
    press(3, 4'b0010, 2);            // bounce, no report

    // Rows 1 and 3 on column 0; short glitch of row1 during hold.
    s = samp(0);
    wait_cyc(s - SD + 1);
    pressed[4] = 1'b1; pressed[12] = 1'b1;
    exp_q.push_back(4); model_code = 4'd4;
    wait_cyc(s + SD*(DB-1));
    chk("multi_held", kif.key_held, 1'b1);
    wait_cyc(s + SD*(DB-1) + 1);
    pressed[4] = 1'b0;
    wait_cyc(s + SD*DB + 1);
    chk("glitch_held", kif.key_held, 1'b1);
    pressed[4] = 1'b1;
    wait_cyc(s + SD*(DB+1) + 1);
    chk("glitch_back_held", kif.key_held, 1'b1);
    wait_cyc(s + SD*(DB+2) + 1);
    pressed[4] = 1'b0; pressed[12] = 1'b0;
    wait_cyc(s + SD*(DB+2) + SD*DB - 1);
    chk("multi_held_tail", kif.key_held, 1'b1);
    wait_cyc(s + SD*(DB+2) + SD*DB);
    chk("multi_released", kif.key_held, 1'b0);
    chk("multi_code", kif.key_code, 4'd4);
    last_e = s + SD*(DB+2) + SD*DB; last_idx = 1;

    press(0, 4'b0001, 6);
    idle(6);
    press(3, 4'b1000, 6);
    chk("code_holds_15", kif.key_code, 4'd15);

    for (int k = 0; k < 12; k++) begin
      int c, h;
      logic [3:0] rows;
      c = $urandom_range(0, 3);
      rows = 4'($urandom_range(1, 15));
      h = ($urandom_range(0, 1) == 1) ? $urandom_range(DB, DB + 3) : $urandom_range(1, DB - 1);
      press(c, rows, h);
      idle($urandom_range(0, 3));
    end

    wait_cyc(last_e + 2*SD);
    chk("queue_drained", 8'(exp_q.size()), 8'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
